rx_frame_parser: RTL and testbench

- RX byte-stream packet deframer. Sits directly downstream of the RX byte deserializer and consumes its byte and byte-qualifier outputs.
- Hunts for preamble plus SFD, then reads the PHY length byte.
- Forwards payload bytes with start/end markers to the MAC-side buffer, and flags malformed or stalled frames.

---
 rtl/rx_frame_pkg.sv | 22 ++
 rtl/rx_crc16.sv | 24 ++
 rtl/rx_frame_parser.sv | 165 ++++++++++++++++
 tb/tb_rx_frame_parser.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the RX deframer: state encoding, default SFD, PHY length width
// and the byte-wise reflected CRC-16 step used when RX_CRC_EN is defined.
package rx_frame_pkg;

    typedef enum logic [1:0] {HUNT, LEN, PLD} state_t;

    localparam logic [7:0]  SFD_DEFAULT   = 8'hA7;
    localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
    localparam int          PHY_LEN_W     = 7;

    // One byte through the reflected CRC-16, data bits taken LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY_REFL;
            else             c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/rx_crc16.sv
// Running 802.15.4 CRC-16 register, one byte per en pulse; clr returns it to the zero seed.
// Result is the registered CRC after the last accepted byte.
module rx_crc16
    import rx_frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      crc_q <= '0;
        else if (clr) crc_q <= '0;
        else if (en)  crc_q <= crc16_byte(crc_q, din);
    end

    assign crc = crc_q;

endmodule

// File: rtl/rx_frame_parser.sv
// RX deframer: preamble/SFD hunt, PHY length, payload forwarding with sof/eof, error and timeout pulses.
// All outputs registered, one cycle after the qualifying byte; define RX_CRC_EN to check the trailing FCS.
module rx_frame_parser
    import rx_frame_pkg::*;
#(
    parameter logic [7:0] SFD         = SFD_DEFAULT,
    parameter int         PRE_BYTES   = 4,
    parameter int         MAX_LEN     = 127,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [7:0]           byte_in,
    input  logic                 byte_in_en,
    output logic [7:0]           pld_data,
    output logic                 pld_valid,
    output logic                 pld_sof,
    output logic                 pld_eof,
    output logic [PHY_LEN_W-1:0] frame_len,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 crc_ok,
    output logic                 busy
);

    localparam int GAP_W = $clog2(TIMEOUT_CYC);
`ifdef RX_CRC_EN
    localparam int MIN_LEN = 2;
`else
    localparam int MIN_LEN = 1;
`endif

    state_t               state_q;
    logic [3:0]           pre_cnt_q;
    logic [PHY_LEN_W-1:0] rem_cnt_q;
    logic [GAP_W-1:0]     gap_cnt_q;
    logic [7:0]           pld_data_q;
    logic                 pld_valid_q, pld_sof_q, pld_eof_q;
    logic [PHY_LEN_W-1:0] frame_len_q;
    logic                 frame_done_q, frame_err_q, crc_ok_q, busy_q;

    logic [PHY_LEN_W-1:0] len;
    logic                 len_ok;
    logic                 gap_expired;
    logic                 crc_pass;

    assign len    = byte_in[PHY_LEN_W-1:0];
    assign len_ok = (len >= PHY_LEN_W'(MIN_LEN)) && (len <= PHY_LEN_W'(MAX_LEN));
    // Fires on the edge where the gap counter would reach TIMEOUT_CYC-1; a coincident byte wins.
    assign gap_expired = !byte_in_en && (gap_cnt_q == GAP_W'(TIMEOUT_CYC - 2));

`ifdef RX_CRC_EN
    logic [15:0] crc_val;

    rx_crc16 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (state_q == HUNT),
        .en  (en && byte_in_en && (state_q == PLD)),
        .din (byte_in),
        .crc (crc_val)
    );

    assign crc_pass = (crc16_byte(crc_val, byte_in) == 16'h0000);
`else
    assign crc_pass = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            pre_cnt_q    <= '0;
            rem_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            pld_data_q   <= '0;
            pld_valid_q  <= 1'b0;
            pld_sof_q    <= 1'b0;
            pld_eof_q    <= 1'b0;
            frame_len_q  <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            crc_ok_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pld_valid_q  <= 1'b0;
            pld_sof_q    <= 1'b0;
            pld_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (!en) begin
                state_q   <= HUNT;
                pre_cnt_q <= '0;
                rem_cnt_q <= '0;
                gap_cnt_q <= '0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    HUNT: if (byte_in_en) begin
                        if (byte_in == 8'h00) begin
                            if (pre_cnt_q != 4'(PRE_BYTES)) pre_cnt_q <= pre_cnt_q + 4'd1;
                        end else if (byte_in == SFD && pre_cnt_q == 4'(PRE_BYTES)) begin
                            state_q   <= LEN;
                            busy_q    <= 1'b1;
                            pre_cnt_q <= '0;
                            gap_cnt_q <= '0;
                        end else begin
                            pre_cnt_q <= '0;
                        end
                    end
                    LEN, PLD: begin
                        if (byte_in_en) begin
                            gap_cnt_q <= '0;
                            if (state_q == LEN) begin
                                if (len_ok) begin
                                    frame_len_q <= len;
                                    rem_cnt_q   <= len;
                                    state_q     <= PLD;
                                end else begin
                                    frame_err_q <= 1'b1;
                                    state_q     <= HUNT;
                                    busy_q      <= 1'b0;
                                end
                            end else begin
                                pld_data_q  <= byte_in;
                                pld_valid_q <= 1'b1;
                                pld_sof_q   <= (rem_cnt_q == frame_len_q);
                                rem_cnt_q   <= rem_cnt_q - PHY_LEN_W'(1);
                                if (rem_cnt_q == PHY_LEN_W'(1)) begin
                                    pld_eof_q    <= 1'b1;
                                    frame_done_q <= 1'b1;
                                    crc_ok_q     <= crc_pass;
                                    state_q      <= HUNT;
                                    busy_q       <= 1'b0;
                                end
                            end
                        end else if (gap_expired) begin
                            frame_err_q <= 1'b1;
                            gap_cnt_q   <= '0;
                            state_q     <= HUNT;
                            busy_q      <= 1'b0;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pld_data   = pld_data_q;
    assign pld_valid  = pld_valid_q;
    assign pld_sof    = pld_sof_q;
    assign pld_eof    = pld_eof_q;
    assign frame_len  = frame_len_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign crc_ok     = crc_ok_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Scoreboard bench for rx_frame_parser: a byte-stream reference model predicts each output event and busy level.
module tb_rx_frame_parser;

    localparam int         TO   = 64;
    localparam int         PRE  = 4;
    localparam int         MAXL = 127;
    localparam logic [7:0] SFDV = 8'hA7;
`ifdef RX_CRC_EN
    localparam int MINL = 2;
    localparam bit HAS_CRC = 1'b1;
`else
    localparam int MINL = 1;
    localparam bit HAS_CRC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_in_en = 1'b0;
    logic [7:0] pld_data;
    logic       pld_valid, pld_sof, pld_eof, frame_done, frame_err, crc_ok, busy;
    logic [6:0] frame_len;

    rx_frame_parser #(.SFD(SFDV), .PRE_BYTES(PRE), .MAX_LEN(MAXL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .en(en), .byte_in(byte_in), .byte_in_en(byte_in_en),
        .pld_data(pld_data), .pld_valid(pld_valid), .pld_sof(pld_sof), .pld_eof(pld_eof),
        .frame_len(frame_len), .frame_done(frame_done), .frame_err(frame_err),
        .crc_ok(crc_ok), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         at;
        bit         err;
        logic [7:0] d;
        bit         sof;
        bit         eof;
        logic [6:0] flen;
        bit         crc_ok;
    } ev_t;
    typedef struct {
        int at;
        bit b;
    } bz_t;
    ev_t evq[$];
    bz_t bzq[$];

    // Reference model: byte-stream view of the framing rules.
    int         zeros, remaining, idle;
    bit         want_len, in_frame, first_m, crc_ok_m;
    logic [6:0] flen_m;
    logic [15:0] crc_m;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r >> 1) ^ (((r[0] ^ d[i]) != 1'b0) ? 16'h8408 : 16'h0000);
        return r;
    endfunction

    task automatic model_reset();
        zeros = 0; remaining = 0; idle = 0;
        want_len = 0; in_frame = 0; first_m = 0;
        crc_ok_m = 0; flen_m = '0; crc_m = '0;
        evq.delete();
        bzq.delete();
    endtask

    task automatic model_step(input bit e, input bit be, input logic [7:0] b);
        int at;
        int l;
        bit last;
        at = cyc + 1;
        if (!e) begin
            zeros = 0; want_len = 0; in_frame = 0; idle = 0;
        end else if ((want_len || in_frame) && !be) begin
            idle++;
            if (idle == TO - 1) begin
                evq.push_back('{at, 1'b1, 8'h00, 1'b0, 1'b0, flen_m, 1'b0});
                want_len = 0; in_frame = 0; idle = 0;
            end
        end else if (be) begin
            if (want_len) begin
                idle = 0;
                want_len = 0;
                l = int'(b[6:0]);
                if (l < MINL || l > MAXL) begin
                    evq.push_back('{at, 1'b1, 8'h00, 1'b0, 1'b0, flen_m, 1'b0});
                end else begin
                    flen_m = 7'(l); remaining = l; first_m = 1; in_frame = 1; crc_m = '0;
                end
            end else if (in_frame) begin
                idle = 0;
                crc_m = crc_upd(crc_m, b);
                last = (remaining == 1);
                if (last) crc_ok_m = HAS_CRC ? (crc_m == 16'h0000) : 1'b1;
                evq.push_back('{at, 1'b0, b, first_m, last, flen_m, crc_ok_m});
                first_m = 0;
                remaining--;
                if (last) in_frame = 0;
            end else if (b == 8'h00) begin
                zeros = (zeros < PRE) ? zeros + 1 : PRE;
            end else if (b == SFDV && zeros == PRE) begin
                want_len = 1; zeros = 0; idle = 0;
            end else begin
                zeros = 0;
            end
        end
        bzq.push_back('{at, want_len || in_frame});
    endtask

    // Monitor: pops the predicted event whenever the DUT pulses an output.
    int   last_err_cyc = -1;
    logic last_done_crc = 1'bx;
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            while (evq.size() > 0 && evq[0].at < cyc) begin
                chk("missed_event", 32'(evq[0].at), 32'(cyc));
                void'(evq.pop_front());
            end
            if (pld_valid || frame_err) begin
                if (frame_err) last_err_cyc = cyc;
                if (frame_done) last_done_crc = crc_ok;
                if (evq.size() == 0 || evq[0].at != cyc) begin
                    chk("unexpected_output", {30'd0, pld_valid, frame_err}, 32'd0);
                end else begin
                    e = evq.pop_front();
                    chk("event", {11'd0, pld_valid, frame_err, pld_sof, pld_eof, frame_done, frame_len,
                                  pld_valid ? pld_data : 8'h00, frame_done ? crc_ok : 1'b0},
                                 {11'd0, !e.err, e.err, e.sof, e.eof, e.eof, e.flen,
                                  e.err ? 8'h00 : e.d, e.eof ? e.crc_ok : 1'b0});
                end
            end
            while (bzq.size() > 0 && bzq[0].at < cyc) void'(bzq.pop_front());
            if (bzq.size() > 0 && bzq[0].at == cyc) begin
                chk("busy", {31'd0, busy}, {31'd0, bzq[0].b});
                void'(bzq.pop_front());
            end
        end
    end

    task automatic step(input bit e, input bit be, input logic [7:0] b);
        @(posedge clk);
        #1;
        en = e; byte_in_en = be; byte_in = b;
        model_step(e, be, b);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, 1'b1, b);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'($urandom));
    endtask

    task automatic pre_sfd();
        repeat (PRE) send(8'h00);
        send(SFDV);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #1;
        byte_in_en = 1'b0;
        @(negedge clk);
        #1;
        chk("busy_before_rst", {31'd0, busy}, {31'd0, (want_len || in_frame)});
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {pld_data, pld_valid, pld_sof, pld_eof, frame_len, frame_done,
                                  frame_err, crc_ok, busy}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_frame();
        int k, npre, plen, gmax;
        logic [7:0] lb;
        k = $urandom_range(0, 9);
        gmax = $urandom_range(0, 2);
        npre = (k == 0) ? $urandom_range(0, PRE - 1) : $urandom_range(PRE, PRE + 2);
        repeat (npre) begin send(8'h00); idles($urandom_range(0, gmax)); end
        send(SFDV);
        idles($urandom_range(0, gmax));
        if (k == 1) begin
            lb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h80;
            if (HAS_CRC && $urandom_range(0, 1) == 1) lb = lb | 8'h01;
            send(lb);
            return;
        end
        plen = ($urandom_range(0, 15) == 0) ? MAXL : $urandom_range(MINL, 24);
        send(8'(plen) | ($urandom_range(0, 1) == 1 ? 8'h80 : 8'h00));
        for (int i = 0; i < plen; i++) begin
            if (k == 2 && i == plen / 2) idles($urandom_range(TO - 3, TO + 2));
            if (k == 3 && i == plen / 2) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            send(8'($urandom));
            idles($urandom_range(0, gmax));
        end
    endtask

    initial begin
        int bb_cyc;
        logic [7:0] chk_bytes[11];
        model_reset();
        #1;
        chk("reset_outputs", {pld_data, pld_valid, pld_sof, pld_eof, frame_len, frame_done,
                              frame_err, crc_ok, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic frame
        pre_sfd(); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        idles(2);
        chk("basic_frame_len", {25'd0, frame_len}, 32'd3);
`ifndef RX_CRC_EN
        chk("crc_ok_default", {31'd0, last_done_crc}, 32'd1);
`endif

        // Short preamble, then single-byte frame
        repeat (3) send(8'h00);
        send(SFDV); send(8'h03); send(8'h11);
        idles(2);
        pre_sfd();
`ifdef RX_CRC_EN
        send(8'h02); send(8'h5A); send(8'h5B);
`else
        send(8'h01); send(8'h5A);
`endif
        idles(2);

        // Bad lengths, then maximum length
        pre_sfd(); send(8'h00); idles(1);
        pre_sfd(); send(8'h80); idles(1);
        pre_sfd(); send(8'h7F);
        for (int i = 0; i < 127; i++) send(8'($urandom));
        idles(2);
        chk("max_len", {25'd0, frame_len}, 32'd127);

        // Timeout after two payload bytes
        pre_sfd(); send(8'h05); send(8'hAA); send(8'hBB);
        bb_cyc = cyc;
        idles(TO + 16);
        chk("timeout_delay", 32'(last_err_cyc - bb_cyc), 32'd64);
        pre_sfd(); send(8'h02); send(8'h10); send(8'h20); idles(2);

        // Gap boundary: TO-2 idle cycles survive, TO-1 expire
        pre_sfd(); send(8'h02); send(8'hAA); idles(TO - 2); send(8'hBB); idles(2);
        pre_sfd(); send(8'h02); send(8'hAA); idles(TO - 1); send(8'hBB); idles(2);

`ifdef RX_CRC_EN
        chk_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h89, 8'h21};
        pre_sfd(); send(8'h0B);
        foreach (chk_bytes[i]) send(chk_bytes[i]);
        idles(2);
        chk("crc_good", {31'd0, last_done_crc}, 32'd1);
        pre_sfd(); send(8'h0B);
        foreach (chk_bytes[i]) send(i == 4 ? (chk_bytes[i] ^ 8'h01) : chk_bytes[i]);
        idles(2);
        chk("crc_bad", {31'd0, last_done_crc}, 32'd0);
`else
        chk_bytes = '{default: 8'h00};
`endif

        // Async reset mid-payload
        pre_sfd(); send(8'h05); send(8'hAA); send(8'hBB);
        reset_mid();
        idles(2);

        // en low for one cycle mid-frame
        pre_sfd(); send(8'h03); send(8'h11);
        step(1'b0, 1'b1, 8'h22);
        send(8'h33); send(8'h44);
        chk("en_abort_flen_hold", {25'd0, frame_len}, 32'd3);
        chk("en_abort_busy", {31'd0, busy}, 32'd0);
        idles(2);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            rand_frame();
            idles($urandom_range(0, 3));
        end

        idles(TO + 4);
        chk("drain", 32'(evq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
